// File: rtl/disp_pkg.sv
// Shared types, constants and the hex-to-7-segment table for the display
// scan controller.
package disp_pkg;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_buf_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Slot prescaler: free-running pre counter, end-of-slot tick, digit index
// and the top three prescaler bits used as the PWM phase.
module disp_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       tick_o,
    output logic [1:0] idx_o,
    output logic [2:0] phase_o
);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;

    assign tick_o  = &pre_q;
    assign idx_o   = idx_q;
    assign phase_o = pre_q[PRE_W-1 -: 3];

    // Next prescaler value and digit index advance on the slot tick.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = tick_o ? idx_q + 2'd1 : idx_q;
    end

    // Counter and digit-index registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pre_q <= '0;
            idx_q <= 2'd0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a double-buffered
// value (committed only at frame end) and PWM brightness.
// Build option: define DISP_LZB_EN to enable leading-zero blanking.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int PRE_W = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [15:0] Digits,
    input  logic [3:0]  DpIn,
    input  logic [3:0]  BlankIn,
    input  logic [2:0]  Bright,
    output logic        Ack,
    output logic [3:0]  An,
    output logic [6:0]  Seg,
    output logic        Dp
);

    logic       tick;
    logic [1:0] idx;
    logic [2:0] phase;

    disp_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .Clk     (Clk),
        .Reset   (Reset),
        .tick_o  (tick),
        .idx_o   (idx),
        .phase_o (phase)
    );

    disp_buf_t  shadow_q, shadow_d;
    disp_buf_t  active_q, active_d;
    logic       pending_q, pending_d;
    logic       ack_q, ack_d;
    logic [2:0] bright_q;
    logic       commit;

    assign commit = tick && (idx == 2'd3) && pending_q;

    // Buffer update: commit hands the old shadow over before a coinciding
    // load replaces it, so that load stays pending for the next frame.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ack_d     = commit;
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (Load) begin
            shadow_d  = '{digits: Digits, dp: DpIn, blank: BlankIn};
            pending_d = 1'b1;
        end
    end

    // Buffer, handshake and brightness registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shadow_q  <= '0;
            active_q  <= '{digits: 16'h0000, dp: 4'h0, blank: 4'hF};
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            bright_q  <= 3'd7;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            bright_q  <= Bright;
        end
    end

    assign Ack = ack_q;

`ifdef DISP_LZB_EN
    // lz[k]: digit k and every digit above it are zero; digit 0 never blanks.
    logic [3:0] lz;
    assign lz[3] = (active_q.digits[15:12] == 4'h0);
    assign lz[2] = lz[3] && (active_q.digits[11:8] == 4'h0);
    assign lz[1] = lz[2] && (active_q.digits[7:4] == 4'h0);
    assign lz[0] = 1'b0;
`endif

    logic [3:0] cur_nib;
    logic       dark;
    logic       on;

    // Output decode for the digit currently being scanned.
    always_comb begin
        cur_nib = active_q.digits[{idx, 2'b00} +: 4];
        dark    = active_q.blank[idx];
`ifdef DISP_LZB_EN
        dark    = dark | (lz[idx] & ~active_q.dp[idx]);
`endif
        on      = ~dark & (phase <= bright_q);
        An      = on ? ~(4'b0001 << idx) : AN_OFF;
        Seg     = on ? hex7seg(cur_nib) : SEG_OFF;
        Dp      = on ? ~active_q.dp[idx] : 1'b1;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Display controller for the BASYS3 4-digit multiplexed 7-segment display (100 MHz Clk).
- Accepts a 4-digit hex value with per-digit decimal points and blanks through a load strobe.
- Double-buffers the value so updates happen only at frame boundaries, with no tearing.
- Scans the digits, drives active-low anodes, segments and DP, and applies PWM brightness.

Parameters:
- PRE_W, default 4, prescaler width. Slot = 2**PRE_W cycles per digit; frame = 4 slots. Minimum 3. Use 18 for implementation (about 95 Hz refresh).

Ports:
- Clk  in  1  system clock
- Reset  in  1  reset
- Load  in  1  single-cycle strobe; captures Digits/DpIn/BlankIn into the shadow buffer
- Digits  in  16  hex nibbles; [3:0] = digit 0 (rightmost)
- DpIn  in  4  decimal point per digit, 1 = lit
- BlankIn  in  4  blank per digit, 1 = dark
- Bright  in  3  live brightness, 7 = full, 0 = 1/8 duty
- Ack  out  1  single-cycle pulse when the shadow buffer is committed to the active buffer
- An  out  4  active-low anodes; An[0] = digit 0
- Seg  out  7  active-low segments {g,f,e,d,c,b,a}
- Dp  out  1  active-low decimal point

Behaviour:
- Reset: reset Reset, asynchronous, active-high; clock Clk.
- Reset values:
  - Prescaler pre = 0, digit index idx = 0, pending = 0, Ack = 0.
  - Active buffer: digits 0, Dp 0, blank 4'hF.
  - Resulting outputs: An = 4'hF, Seg = 7'h7F, Dp = 1.
- Prescaler: pre increments every cycle and wraps. Tick is the cycle where pre is all ones. idx increments on tick, wrapping 3 -> 0.
- Load: on a Load edge, the shadow buffer captures the inputs and pending is set. Load while pending overwrites the shadow (last load wins).
- Commit: on the tick edge where idx == 3 and pending == 1:
  - active <= shadow (the value before this edge), pending <= 0, Ack = 1 for exactly the following cycle.
  - If Load coincides with a commit edge, the old shadow commits and the new capture stays pending for the next frame.
- No Load: no commit and no Ack; the display repeats the active buffer indefinitely.
- Output decode is combinational from registered state (idx, pre, active, Bright):
  - on = ~blank[idx] and (pre[PRE_W-1 -: 3] <= Bright).
  - An = on ? ~(4'b0001 << idx) : 4'hF.
  - Seg = on ? hex7seg(digit[idx]) : 7'h7F.
  - Dp = on ? ~dp[idx] : 1.
- Bright changes take effect in the next cycle; no synchronisation to the frame.
- Reset mid-frame: outputs return to reset values immediately and pending/shadow are discarded.

Optional Feature:
- Macro DISP_LZB_EN.
- Defined: leading-zero blanking. Digit k (k = 3..1) is dark when it and every higher digit in the active buffer are 0. Digit 0 is never suppressed. This is ORed with blank[k]. Dp still forces that digit on when dp[k] = 1.
- Undefined: zeros are displayed as '0'.

Decomposition:
- Package disp_pkg holds:
  - typedef disp_buf_t struct (digits[15:0], dp[3:0], blank[3:0]).
  - Constants SEG_OFF = 7'h7F and AN_OFF = 4'hF.
  - Function hex7seg as a 16-entry table, active-low {g,f,e,d,c,b,a}: 0 = 7'b1000000, 4 = 7'b0011001, 5 = 7'b0010010, F = 7'b0001110.
- One sub-module disp_prescaler owns the pre counter, tick and idx.

Test Plan (PRE_W = 4, slot = 16 cycles, frame = 64 cycles):
- Reset, then 128 idle cycles -> An = 1111, Seg = 7'h7F, Dp = 1, Ack never asserted.
- Load Digits = 16'h1234, DpIn = 0, BlankIn = 0, Bright = 7 at cycle 5 -> one Ack pulse at cycle 64. Then slot 0: An = 1110, Seg = 7'b0011001 for all 16 cycles. Slot 3: An = 0111, Seg shows '1'.
- Load 16'h1111 at cycle 10 and 16'h2222 at cycle 20 -> single Ack; display shows 2222; 1111 never appears.
- Bright = 0 with a committed value -> each anode low only for pre = 0..1 (2 of 16 cycles per slot). Bright = 3 -> low for 8 of 16.
- Reset asserted mid-slot with a load pending -> outputs go to reset values asynchronously. After release: no Ack and blank display.
- With DISP_LZB_EN, Digits = 16'h0050, DpIn = 4'b0100 -> digit 3 dark, digit 2 shows '0' with DP, digit 1 shows '5', digit 0 shows '0'. Without the macro, digit 3 shows '0'.
